// File: rtl/mv_seq_ctrl.sv
// Sequencing controller for the matrix-vector MAC lane: walks an MxN row-major matrix,
// tags each read so the MAC strobes line up RD_LAT later, and writes one result per row.
module mv_seq_ctrl #(
    parameter  int N          = 4,
    parameter  int M          = 4,
    parameter  int BRAM_DEPTH = 32,
    parameter  int RD_LAT     = 1,
    parameter  int MAC_LAT    = 1,
    localparam int AW         = $clog2(BRAM_DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          start_i,
    input  logic          stall_i,
    input  logic [AW-1:0] rd_base_i,
    input  logic [AW-1:0] wr_base_i,
    output logic          rd_en_o,
    output logic [AW-1:0] rd_addr_o,
    output logic          init_o,
    output logic          acc_en_o,
    output logic          shift_en_o,
    output logic          mem_wr_en_o,
    output logic [AW-1:0] wr_addr_o,
    output logic          busy_o,
    output logic          done_o
);
    localparam int CW = $clog2(N) + 1;
    localparam int RW = $clog2(M) + 1;
    localparam logic [CW-1:0] COL_LAST = CW'(N - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(M - 1);

    typedef enum logic [1:0] {StIdle, StRead, StDrain, StDone} stateT;

    stateT              state_q;
    logic [CW-1:0]      col_q;
    logic [RW-1:0]      row_q;
    logic [RW-1:0]      wrCnt_q;
    logic [AW-1:0]      rdBase_q;
    logic [AW-1:0]      wrAddr_q;
    logic [RD_LAT-1:0]  tagValid_q;
    logic [RD_LAT-1:0]  tagFirst_q;
    logic [RD_LAT-1:0]  tagLast_q;
    logic [MAC_LAT-1:0] wrPipe_q;
    logic               shiftOn_q;

    logic          accept;
    logic          rdEn;
    logic          rowLastAcc;
    logic [AW-1:0] rowOffset;

    assign accept     = start_i && (state_q == StIdle || state_q == StDone);
    assign rdEn       = (state_q == StRead) && !stall_i;
    assign rowOffset  = AW'(int'(row_q) * N);
    assign rowLastAcc = acc_en_o && tagLast_q[RD_LAT-1];

    assign rd_en_o     = rdEn;
    assign rd_addr_o   = rdBase_q + rowOffset + AW'(col_q);
    assign acc_en_o    = tagValid_q[RD_LAT-1];
    assign init_o      = acc_en_o && tagFirst_q[RD_LAT-1];
    assign shift_en_o  = init_o || shiftOn_q;
    assign mem_wr_en_o = wrPipe_q[MAC_LAT-1];
    assign wr_addr_o   = wrAddr_q;
    assign busy_o      = (state_q == StRead) || (state_q == StDrain);
    assign done_o      = (state_q == StDone);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            col_q    <= '0;
            row_q    <= '0;
            rdBase_q <= '0;
        end else begin
            case (state_q)
                StIdle, StDone: begin
                    state_q <= StIdle;
                    if (start_i) begin
                        state_q  <= StRead;
                        rdBase_q <= rd_base_i;
                        col_q    <= '0;
                        row_q    <= '0;
                    end
                end
                StRead: begin
                    if (!stall_i) begin
                        if (col_q == COL_LAST) begin
                            col_q <= '0;
                            if (row_q == ROW_LAST) begin
                                state_q <= StDrain;
                            end else begin
                                row_q <= row_q + 1'b1;
                            end
                        end else begin
                            col_q <= col_q + 1'b1;
                        end
                    end
                end
                StDrain: begin
                    if (mem_wr_en_o && wrCnt_q == ROW_LAST) begin
                        state_q <= StDone;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Tags shift every cycle regardless of stall; a stalled cycle simply injects an empty slot.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tagValid_q <= '0;
            tagFirst_q <= '0;
            tagLast_q  <= '0;
            wrPipe_q   <= '0;
            shiftOn_q  <= 1'b0;
            wrAddr_q   <= '0;
            wrCnt_q    <= '0;
        end else begin
            tagValid_q <= RD_LAT'({tagValid_q, rdEn});
            tagFirst_q <= RD_LAT'({tagFirst_q, (col_q == '0)});
            tagLast_q  <= RD_LAT'({tagLast_q, (col_q == COL_LAST)});
            wrPipe_q   <= MAC_LAT'({wrPipe_q, rowLastAcc});
            if (acc_en_o) begin
                shiftOn_q <= !tagLast_q[RD_LAT-1];
            end
            if (accept) begin
                wrAddr_q <= wr_base_i;
                wrCnt_q  <= '0;
            end else if (mem_wr_en_o) begin
                wrAddr_q <= wrAddr_q + 1'b1;
                wrCnt_q  <= wrCnt_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mv_seq_ctrl.sv
// Bench for mv_seq_ctrl: four parameter sets share one stimulus stream and are checked
// cycle by cycle against an element-index/event-schedule model of the job timing.
module tb_mv_seq_ctrl;
    localparam int NINST = 4;
    localparam int DEPTH = 32;
    localparam int AW    = 5;
    localparam int MAXC  = 4096;
    localparam int CN  [NINST] = '{4, 3, 2, 1};
    localparam int CM  [NINST] = '{2, 2, 2, 3};
    localparam int CRL [NINST] = '{1, 3, 1, 2};
    localparam int CML [NINST] = '{1, 2, 2, 1};

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          stall;
    logic [AW-1:0] rdBase;
    logic [AW-1:0] wrBase;

    wire [NINST-1:0]         rdEn;
    wire [NINST-1:0][AW-1:0] rdAddr;
    wire [NINST-1:0]         initS;
    wire [NINST-1:0]         accEn;
    wire [NINST-1:0]         shiftEn;
    wire [NINST-1:0]         memWrEn;
    wire [NINST-1:0][AW-1:0] wrAddr;
    wire [NINST-1:0]         busy;
    wire [NINST-1:0]         done;

    int cycle      = 0;
    int checkCount = 0;
    int errorCount = 0;

    // Reference model state: expected events indexed by absolute cycle number.
    bit evAcc    [NINST][MAXC];
    bit evFirst  [NINST][MAXC];
    bit evLast   [NINST][MAXC];
    bit evWr     [NINST][MAXC];
    int evWrAddr [NINST][MAXC];
    bit active    [NINST];
    bit openRow   [NINST];
    int nextElem  [NINST];
    int doneCycle [NINST];
    int jobRdBase [NINST];
    int jobWrBase [NINST];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NINST; g++) begin : gDut
        mv_seq_ctrl #(
            .N          (CN[g]),
            .M          (CM[g]),
            .BRAM_DEPTH (DEPTH),
            .RD_LAT     (CRL[g]),
            .MAC_LAT    (CML[g])
        ) dut (
            .clk_i       (clk),
            .rst_ni      (rst_n),
            .start_i     (start),
            .stall_i     (stall),
            .rd_base_i   (rdBase),
            .wr_base_i   (wrBase),
            .rd_en_o     (rdEn[g]),
            .rd_addr_o   (rdAddr[g]),
            .init_o      (initS[g]),
            .acc_en_o    (accEn[g]),
            .shift_en_o  (shiftEn[g]),
            .mem_wr_en_o (memWrEn[g]),
            .wr_addr_o   (wrAddr[g]),
            .busy_o      (busy[g]),
            .done_o      (done[g])
        );
    end

    task automatic checkOutput(input string tag, input int k, input logic [31:0] got,
                               input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s inst%0d cycle %0d: got %0h, expected %0h",
                     tag, k, cycle, got, exp);
        end
    endtask

    task automatic modelStep();
        int n, m, rl, ml, col, row;
        bit eRd, eAcc, eInit, eShift, eWr, eBusy;
        for (int k = 0; k < NINST; k++) begin
            n  = CN[k];
            m  = CM[k];
            rl = CRL[k];
            ml = CML[k];
            if (!rst_n) begin
                checkOutput("rd_en",     k, 32'(rdEn[k]),    32'd0);
                checkOutput("rd_addr",   k, 32'(rdAddr[k]),  32'd0);
                checkOutput("init",      k, 32'(initS[k]),   32'd0);
                checkOutput("acc_en",    k, 32'(accEn[k]),   32'd0);
                checkOutput("shift_en",  k, 32'(shiftEn[k]), 32'd0);
                checkOutput("mem_wr_en", k, 32'(memWrEn[k]), 32'd0);
                checkOutput("wr_addr",   k, 32'(wrAddr[k]),  32'd0);
                checkOutput("busy",      k, 32'(busy[k]),    32'd0);
                checkOutput("done",      k, 32'(done[k]),    32'd0);
                active[k]    = 1'b0;
                openRow[k]   = 1'b0;
                doneCycle[k] = -1;
                for (int t = cycle; t < cycle + 16 && t < MAXC; t++) begin
                    evAcc[k][t] = 1'b0;
                    evWr[k][t]  = 1'b0;
                end
            end else begin
                eRd    = active[k] && (nextElem[k] < n * m) && !stall;
                eAcc   = evAcc[k][cycle];
                eInit  = eAcc && evFirst[k][cycle];
                eShift = eInit || openRow[k];
                eWr    = evWr[k][cycle];
                eBusy  = active[k];
                checkOutput("rd_en", k, 32'(rdEn[k]), 32'(eRd));
                if (eRd) begin
                    checkOutput("rd_addr", k, 32'(rdAddr[k]), (jobRdBase[k] + nextElem[k]) % DEPTH);
                end
                checkOutput("acc_en",    k, 32'(accEn[k]),   32'(eAcc));
                checkOutput("init",      k, 32'(initS[k]),   32'(eInit));
                checkOutput("shift_en",  k, 32'(shiftEn[k]), 32'(eShift));
                checkOutput("mem_wr_en", k, 32'(memWrEn[k]), 32'(eWr));
                if (eWr) begin
                    checkOutput("wr_addr", k, 32'(wrAddr[k]), evWrAddr[k][cycle]);
                end
                checkOutput("busy", k, 32'(busy[k]), 32'(eBusy));
                checkOutput("done", k, 32'(done[k]), 32'(cycle == doneCycle[k]));

                if (eAcc) begin
                    openRow[k] = !evLast[k][cycle];
                end
                if (eRd) begin
                    col = nextElem[k] % n;
                    row = nextElem[k] / n;
                    evAcc[k][cycle + rl]   = 1'b1;
                    evFirst[k][cycle + rl] = (col == 0);
                    evLast[k][cycle + rl]  = (col == n - 1);
                    if (col == n - 1) begin
                        evWr[k][cycle + rl + ml]     = 1'b1;
                        evWrAddr[k][cycle + rl + ml] = (jobWrBase[k] + row) % DEPTH;
                    end
                    nextElem[k]++;
                    if (nextElem[k] == n * m) begin
                        doneCycle[k] = cycle + rl + ml + 1;
                    end
                end
                if (active[k] && doneCycle[k] == cycle + 1) begin
                    active[k] = 1'b0;
                end
                if (!eBusy && start) begin
                    active[k]    = 1'b1;
                    nextElem[k]  = 0;
                    jobRdBase[k] = int'(rdBase);
                    jobWrBase[k] = int'(wrBase);
                end
            end
        end
    endtask

    task automatic applyStimulus(input logic rstVal, input logic startVal, input logic stallVal,
                                 input int rb, input int wb);
        @(posedge clk);
        #1;
        rst_n  = rstVal;
        start  = startVal;
        stall  = stallVal;
        rdBase = AW'(rb);
        wrBase = AW'(wb);
        @(negedge clk);
        modelStep();
        cycle++;
    endtask

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        stall  = 1'b0;
        rdBase = '0;
        wrBase = '0;
        for (int k = 0; k < NINST; k++) begin
            doneCycle[k] = -1;
        end

        repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 0, 0);
        repeat (2) applyStimulus(1'b1, 1'b0, 1'b0, 0, 0);

        $display("[TB] basic job, bases 0");
        applyStimulus(1'b1, 1'b1, 1'b0, 0, 0);
        repeat (16) applyStimulus(1'b1, 1'b0, 1'b0, 0, 0);

        $display("[TB] stall two cycles mid-row");
        applyStimulus(1'b1, 1'b1, 1'b0, 0, 0);
        for (int i = 1; i <= 16; i++) applyStimulus(1'b1, 1'b0, (i == 3 || i == 4), 0, 0);

        $display("[TB] base wrap 30/31");
        applyStimulus(1'b1, 1'b1, 1'b0, 30, 31);
        repeat (16) applyStimulus(1'b1, 1'b0, 1'b0, 0, 0);

        $display("[TB] start held high");
        repeat (40) applyStimulus(1'b1, 1'b1, 1'b0, 5, 9);
        repeat (16) applyStimulus(1'b1, 1'b0, 1'b0, 0, 0);

        $display("[TB] start pulsed mid-job");
        applyStimulus(1'b1, 1'b1, 1'b0, 3, 4);
        repeat (2) applyStimulus(1'b1, 1'b0, 1'b0, 0, 0);
        applyStimulus(1'b1, 1'b1, 1'b0, 20, 20);
        repeat (14) applyStimulus(1'b1, 1'b0, 1'b0, 0, 0);

        $display("[TB] reset mid-read");
        applyStimulus(1'b1, 1'b1, 1'b0, 7, 7);
        repeat (2) applyStimulus(1'b1, 1'b0, 1'b0, 0, 0);
        repeat (2) applyStimulus(1'b0, 1'b1, 1'b0, 0, 0);
        applyStimulus(1'b1, 1'b1, 1'b0, 12, 2);
        repeat (16) applyStimulus(1'b1, 1'b0, 1'b0, 0, 0);

        $display("[TB] random traffic");
        for (int i = 0; i < 1500; i++) begin
            applyStimulus(($urandom_range(0, 199) != 0), ($urandom_range(0, 5) == 0),
                          ($urandom_range(0, 3) == 0),
                          int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, DEPTH - 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/mv_seq_ctrl.md
# mv_seq_ctrl

Parametrised sequencing controller for the matrix-vector datapath: walks an M×N matrix stored row-major in BRAM, issues one read per cycle, and generates the `init`/`acc_en` strobes that drive the MAC lane. Once each row's dot product is complete, it issues one result write per row. It sits between the BRAM read port, the MAC/shift datapath and the result BRAM write port. It adds a start/busy/done handshake, base-address offsets, stall support and configurable read and MAC latencies.

## Interface
- `N`, 4: elements per row (dot-product length), N ≥ 1
- `M`, 4: rows per job, M ≥ 1
- `BRAM_DEPTH`, 32: depth of source and result BRAMs; AW = $clog2(BRAM_DEPTH)
- `RD_LAT`, 1: BRAM read latency in cycles, ≥ 1
- `MAC_LAT`, 1: cycles from the last `acc_en` of a row to a valid result, ≥ 1

Ports:
- `clk` in 1: single clock, all logic rising-edge
- `rst_n` in 1: asynchronous, active-low reset
- `start` in 1: job request; accepted on a rising edge when `busy`==0
- `stall` in 1: while high, no new read is issued; pipeline stages keep advancing
- `rd_base` in AW: source matrix base address, sampled at accept
- `wr_base` in AW: result vector base address, sampled at accept
- `rd_en` out 1: BRAM read strobe
- `rd_addr` out AW: BRAM read address
- `init` out 1: first element of a row; aligned with `acc_en`, clears the accumulator
- `acc_en` out 1: read data valid for the MAC; this is `rd_en` delayed by RD_LAT
- `shift_en` out 1: high from the first `acc_en` to the last `acc_en` of a row, inclusive
- `mem_wr_en` out 1: result write strobe
- `wr_addr` out AW: result write address
- `busy` out 1: job in progress
- `done` out 1: one-cycle completion pulse

## Operation
- States are IDLE, READ, DRAIN and DONE. The reset state is IDLE.
- **IDLE:**
  - On `start`, latch `rd_base` and `wr_base`, clear the column counter `col` (0..N-1) and the row counter `row` (0..M-1), and go to READ.
- **READ:**
  - Each cycle with `stall`==0, assert `rd_en` with `rd_addr` = `rd_base` + `row`·N + `col`, then advance `col`.
  - When `col` wraps to 0, increment `row`.
  - When the read at `row`=M-1, `col`=N-1 issues, go to DRAIN.
  - Cycles with `stall`==1 give `rd_en`=0 and leave the counters frozen.
- **Tag pipeline:**
  - The tag {valid, first, last} travels with every read, where first = (`col`==0) and last = (`col`==N-1).
  - After RD_LAT stages it drives `acc_en`, `init` (= valid & first) and the `shift_en` set/clear.
  - The tag is unaffected by `stall`.
- **Writeback:**
  - A last-tagged `acc_en` schedules `mem_wr_en` MAC_LAT cycles later.
  - `wr_addr` starts at `wr_base` and increments after each write.
- **DRAIN:**
  - Wait until the M-th `mem_wr_en` has been issued, then go to DONE.
- **DONE:**
  - Pulse `done` for one cycle, with `busy`=0. Then return to IDLE.
  - A `start` present in the DONE cycle is accepted exactly as in IDLE.
- `start` while `busy`==1 is ignored; no queuing.
- All address arithmetic is modulo BRAM_DEPTH (AW-bit wrap). No error flag is raised.
- Counters are sized $clog2(N)+1 and $clog2(M)+1. The row-offset product is truncated to AW bits.
- N==1: every `acc_en` carries both `init` and last. `shift_en` is high for that single cycle.

## Timing
- All outputs reset to 0 immediately on `rst_n` low. The state returns to IDLE and all pipeline tags are cleared.
- A reset mid-job produces no further `rd_en` or `mem_wr_en`, and `done` is not pulsed.
- `busy` is 1 from the cycle after accept through the cycle of the final `mem_wr_en`.
- First `rd_en`: the cycle after accept.
- `acc_en` lags `rd_en` by RD_LAT. `mem_wr_en` lags the row's last `acc_en` by MAC_LAT.
- No-stall latency from the accept edge to `done` is M·N + RD_LAT + MAC_LAT + 1 cycles. Each stall cycle during READ adds 1.
- Reads are back-to-back across row boundaries; there is no bubble between rows.

## Test plan
- **Basic job** (N=4, M=2, RD_LAT=1, MAC_LAT=1, bases 0, start at cycle 0):
  - `rd_en` in cycles 1–8 with addresses 0–7.
  - `acc_en` in cycles 2–9; `init` at cycles 2 and 6.
  - `mem_wr_en` at cycle 6 (addr 0) and cycle 10 (addr 1).
  - `done` at cycle 11; `busy` in cycles 1–10.
- **Stall:** same job with `stall` high in cycles 3–4.
  - `rd_addr` 2 is reissued in cycle 5; no `rd_en` in cycles 3–4.
  - `done` moves to cycle 13; `init` stays aligned to addresses 0 and 4.
- **Base and wrap** (`rd_base`=30, `wr_base`=31, BRAM_DEPTH=32, N=2, M=2):
  - Reads go to 30, 31, 0, 1.
  - Writes go to 31, then 0.
- **Latency sweep:** RD_LAT=3, MAC_LAT=2.
  - `acc_en` sits exactly 3 cycles after each `rd_en`.
  - Each `mem_wr_en` sits 2 cycles after the row's last `acc_en`.
  - Total latency = M·N + 6.
- **Handshake:**
  - `start` held high throughout: the next job is accepted in the DONE cycle.
  - `start` pulsed mid-job: ignored.
  - `rst_n` low mid-READ: all outputs are 0 and there is no `done`; a new job after release runs cleanly from `rd_base`.
- **Degenerate N=1, M=3:**
  - `init`, `acc_en` and `shift_en` are all high together on every element.
  - Three writes occur, to `wr_base` through `wr_base`+2.
